// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller.
// Resolves load-use interlocks, taken-branch flushes and multi-cycle memory
// freezes, and keeps a saturating count of fetch-stall cycles.
module hazard_ctrl #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic [4:0]       WriteRegE,
    input  logic             memReadE,
    input  logic             memReqM,
    input  logic             branchTakenE,
    output logic             enF,
    output logic             enFD,
    output logic             flushFD,
    output logic             enA,
    output logic             sendNop,
    output logic             enM,
    output logic             memBusy,
    output logic [CNT_W-1:0] stallCycles
);

    // Wait counter is at least 2 bits wide, wider only for long latencies.
    localparam int CW = (MEM_LAT > 4) ? $clog2(MEM_LAT) : 2;
    // A single-cycle memory never needs to freeze the pipeline.
    localparam logic LONG_MEM = (MEM_LAT > 1);
    localparam logic [CW-1:0] CNT_LOAD = (MEM_LAT > 1) ? CW'(MEM_LAT - 2) : '0;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              frozen;
    logic              loadUse;

    // Hazard detection: memory freeze and load-use match (x0 never interlocks).
    always_comb begin
        frozen  = ((state_q == RUN) && memReqM && LONG_MEM) ||
                  ((state_q == MEMWAIT) && (cnt_q != '0));
        loadUse = memReadE && (WriteRegE != 5'd0) &&
                  ((useRs1D && (rs1D == WriteRegE)) ||
                   (useRs2D && (rs2D == WriteRegE)));
    end

    // Mealy control outputs; priority reset > freeze > branch > load-use.
    always_comb begin
        enF     = 1'b1;
        enFD    = 1'b1;
        flushFD = 1'b0;
        enA     = 1'b1;
        sendNop = 1'b0;
        enM     = 1'b1;
        memBusy = (state_q == MEMWAIT);
        if (reset) begin
            // Keep everything moving but fill the registers with bubbles.
            flushFD = 1'b1;
            sendNop = 1'b1;
            memBusy = 1'b0;
        end else if (frozen) begin
            enF  = 1'b0;
            enFD = 1'b0;
            enA  = 1'b0;
            enM  = 1'b0;
        end else if (branchTakenE) begin
            // Decode holds a wrong-path instruction, so load-use is moot.
            flushFD = 1'b1;
            sendNop = 1'b1;
        end else if (loadUse) begin
            enF     = 1'b0;
            enFD    = 1'b0;
            sendNop = 1'b1;
        end
    end

    // Next-state logic for the memory wait FSM and the stall counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        case (state_q)
            RUN: begin
                if (memReqM && LONG_MEM) begin
                    state_d = MEMWAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            MEMWAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Release cycle: memReqM is not looked at here.
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (!enF && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset abandons any memory wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stallCycles = stall_q;

endmodule
